ddram_arbiter: RTL and testbench
================================

DDRAM_ARBITER -- requirements
Module: ddram_arbiter

Interface
REQ-001 SHALL have parameter NCLI, default 4, number of requesting clients; client 0 is the video refresh port.
REQ-002 SHALL have parameter VGA_MAX_RUN, default 4, maximum consecutive client-0 grants while another client is pending.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cli_req  input  NCLI  per-client request, held high until that client's cli_done.
REQ-006 SHALL have port cli_write  input  NCLI  per-client direction: 1 = write, 0 = read.
REQ-007 SHALL have port cli_addr  input  NCLI x 29  per-client 64-bit word address.
REQ-008 SHALL have port cli_wdata  input  NCLI x 64  per-client write data.
REQ-009 SHALL have port cli_be  input  NCLI x 8  per-client byte enables.
REQ-010 SHALL have port cli_done  output  NCLI  one-cycle completion pulse per client.
REQ-011 SHALL have port cli_rdata  output  64  read data shared by all clients, valid with cli_done.
REQ-012 SHALL have ports DDRAM_BUSY, DDRAM_DOUT[63:0] and DDRAM_DOUT_READY  input; DDRAM_ADDR[28:0], DDRAM_BURSTCNT[7:0], DDRAM_RD, DDRAM_WE, DDRAM_DIN[63:0] and DDRAM_BE[7:0]  output; the usual MiSTer DDR3 semantics apply, with BUSY acting as waitrequest.

Function
REQ-013 SHALL implement the states IDLE, ISSUE and RDWAIT.
REQ-014 SHALL sample cli_req only in IDLE; with any request pending, it latches the winner index, addr, wdata, be and write, then moves to ISSUE on the next edge.
REQ-015 SHALL use this winner rule: client 0 wins unless the run counter equals VGA_MAX_RUN and some client 1..NCLI-1 is pending; those clients are chosen round-robin starting at rr_ptr.
REQ-016 SHALL advance rr_ptr to the client after the one granted whenever it grants a client 1..NCLI-1, wrapping NCLI-1 to 1.
REQ-017 SHALL increment the run counter on each client-0 grant, saturating at VGA_MAX_RUN; any other grant clears it.
REQ-018 SHALL drive DDRAM_RD or DDRAM_WE high in ISSUE, with address, data and byte enables stable from the latched registers, and hold them while DDRAM_BUSY=1.
REQ-019 SHALL drive DDRAM_BURSTCNT to 1 at all times.
REQ-020 SHALL treat a write as accepted on the edge where WE=1 and BUSY=0; on that edge it deasserts WE, returns to IDLE and pulses cli_done[winner] in the following cycle.
REQ-021 SHALL treat a read as accepted on the edge where RD=1 and BUSY=0; on that edge it deasserts RD and enters RDWAIT.
REQ-022 SHALL, in RDWAIT with DOUT_READY=1, register DDRAM_DOUT into cli_rdata, pulse cli_done[winner] for one cycle and return to IDLE.
REQ-023 SHALL hold cli_rdata until the next read completes.
REQ-024 SHALL keep each cli_done pulse exactly one cycle long, with at most one bit set at a time.
REQ-025 SHALL ignore DOUT_READY outside RDWAIT.
REQ-026 SHALL complete a transaction once latched, even if the client drops cli_req, and still issue cli_done.
REQ-027 SHALL give minimum latencies of req to RD/WE = 1 cycle, and write req to done = 2 cycles with BUSY=0.
REQ-028 SHALL allow back-to-back service with one IDLE cycle between transactions.
REQ-029 SHALL let a pending requester see its done in the same cycle that IDLE re-arbitrates; a client must deassert req or present its next request in that cycle.

Reset
REQ-030 SHALL, on reset_n=0, immediately force state IDLE, with DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, cli_done and cli_rdata all 0.
REQ-031 SHALL reset rr_ptr to 1 and the run counter to 0.
REQ-032 SHALL abandon any in-flight transaction on reset without issuing cli_done; late DOUT_READY after reset is ignored by REQ-025.

Structure
REQ-033 SHALL take the state enum, address and data width constants and client index constants (CLI_VGA=0) from package ddram_arb_pkg.
REQ-034 SHALL place the round-robin selection in one combinational sub-module ddram_arb_pick (inputs: pending mask, rr_ptr; outputs: winner index, valid).

Verification
REQ-035 SHALL verify a single write: client 2 writes addr 0x0001234, data 0xDEADBEEF_CAFEF00D, be 0xFF, BUSY=0 -> WE for 1 cycle with those values and cli_done[2] 2 cycles after req.
REQ-036 SHALL verify a read under busy: client 1 reads addr 0x10, BUSY held 3 cycles, DOUT_READY 5 cycles later with 0x0123456789ABCDEF -> RD held 4 cycles, cli_rdata=0x0123456789ABCDEF with cli_done[1].
REQ-037 SHALL verify the VGA run limit: client 0 and client 3 requesting continuously -> grant order 0,0,0,0,3,0,0,0,0,3.
REQ-038 SHALL verify round-robin: clients 1, 2 and 3 requesting continuously -> grant order 1,2,3,1,2,3.
REQ-039 SHALL verify reset mid-read: reset_n low in RDWAIT, then DOUT_READY after release -> no cli_done, state IDLE, all outputs 0.
REQ-040 SHALL verify dropped request: client 2 deasserts req during ISSUE -> transaction still issued and cli_done[2] still pulses.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// Shared types and constants for the DDR3 client arbiter.
package ddram_arb_pkg;

  // DDR3 word interface widths (64-bit words, 29-bit word address).
  localparam int unsigned ADDR_W  = 29;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BE_W    = 8;
  localparam int unsigned BURST_W = 8;

  // Client 0 is always the video refresh port; round-robin covers 1..NCLI-1.
  localparam int unsigned CLI_VGA  = 0;
  localparam int unsigned RR_FIRST = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  // Index width that stays legal for degenerate single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddram_arb_pick.sv
// Round-robin selector over clients 1..NCLI-1, scanning from rr_ptr_i.
module ddram_arb_pick
  import ddram_arb_pkg::*;
#(
  parameter int unsigned NCLI = 4,
  parameter int unsigned IW   = idx_width(NCLI)
) (
  input  logic [NCLI-1:0] pend_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            valid_o
);

  int unsigned     idx;
  logic            found;
  logic [NCLI-1:0] pend_sh;

  // First pending client at or after rr_ptr_i, wrapping NCLI-1 back to 1; bit 0 is never a candidate.
  always_comb begin
    win_o   = '0;
    found   = 1'b0;
    idx     = RR_FIRST;
    pend_sh = '0;
    for (int unsigned k = 0; k < NCLI - 1; k++) begin
      idx     = ((32'(rr_ptr_i) + k - 1) % (NCLI - 1)) + 1;
      pend_sh = pend_i >> idx;
      if (!found && pend_sh[0]) begin
        found = 1'b1;
        win_o = IW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ddram_arbiter.sv
// Single-outstanding DDR3 arbiter: video port 0 has priority with a bounded
// run length, other clients share the remaining slots round-robin.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int unsigned NCLI        = 4,
  parameter int unsigned VGA_MAX_RUN = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic [NCLI-1:0]          cli_req,
  input  logic [NCLI-1:0]          cli_write,
  input  logic [NCLI*ADDR_W-1:0]   cli_addr,
  input  logic [NCLI*DATA_W-1:0]   cli_wdata,
  input  logic [NCLI*BE_W-1:0]     cli_be,
  output logic [NCLI-1:0]          cli_done,
  output logic [DATA_W-1:0]        cli_rdata,

  input  logic                     DDRAM_BUSY,
  output logic [BURST_W-1:0]       DDRAM_BURSTCNT,
  output logic [ADDR_W-1:0]        DDRAM_ADDR,
  input  logic [DATA_W-1:0]        DDRAM_DOUT,
  input  logic                     DDRAM_DOUT_READY,
  output logic                     DDRAM_RD,
  output logic [DATA_W-1:0]        DDRAM_DIN,
  output logic [BE_W-1:0]          DDRAM_BE,
  output logic                     DDRAM_WE
);

  localparam int unsigned IW = idx_width(NCLI);
  localparam int unsigned RW = idx_width(VGA_MAX_RUN + 1);

  arb_state_e        state_q;
  logic              rd_q;
  logic              we_q;
  logic              write_q;
  logic [IW-1:0]     win_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [NCLI-1:0]   done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [IW-1:0]     rr_q;
  logic [RW-1:0]     run_q;

  logic              any_pend;
  logic              vga_hold;
  logic [IW-1:0]     rr_win;
  logic              rr_valid;
  logic [IW-1:0]     win_d;
  logic              sel_write_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic [BE_W-1:0]   sel_be_d;
  logic [RW-1:0]     run_d;
  logic [IW-1:0]     rr_d;

  ddram_arb_pick #(
    .NCLI (NCLI),
    .IW   (IW)
  ) u_pick (
    .pend_i   (cli_req),
    .rr_ptr_i (rr_q),
    .win_o    (rr_win),
    .valid_o  (rr_valid)
  );

  // Winner selection and the request fields/bookkeeping it implies.
  always_comb begin
    any_pend = |cli_req;
    vga_hold = (run_q == RW'(VGA_MAX_RUN)) && rr_valid;

    if (cli_req[CLI_VGA] && !vga_hold) begin
      win_d = IW'(CLI_VGA);
    end else begin
      win_d = rr_win;
    end

    sel_write_d = |(cli_write & (NCLI'(1) << win_d));
    sel_addr_d  = ADDR_W'(cli_addr  >> (32'(win_d) * ADDR_W));
    sel_wdata_d = DATA_W'(cli_wdata >> (32'(win_d) * DATA_W));
    sel_be_d    = BE_W'(cli_be      >> (32'(win_d) * BE_W));

    // Video grants extend the run (saturating); any other grant ends it and moves the pointer past the winner.
    run_d = '0;
    rr_d  = rr_q;
    if (win_d == IW'(CLI_VGA)) begin
      run_d = (run_q == RW'(VGA_MAX_RUN)) ? run_q : run_q + RW'(1);
    end else begin
      rr_d = (rr_win == IW'(NCLI - 1)) ? IW'(RR_FIRST) : rr_win + IW'(1);
    end
  end

  // Transaction FSM with all DDR and client-side outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      write_q <= 1'b0;
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      rr_q    <= IW'(RR_FIRST);
      run_q   <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_pend) begin
            win_q   <= win_d;
            write_q <= sel_write_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            be_q    <= sel_be_d;
            we_q    <= sel_write_d;
            rd_q    <= !sel_write_d;
            run_q   <= run_d;
            rr_q    <= rr_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!DDRAM_BUSY) begin
            rd_q <= 1'b0;
            we_q <= 1'b0;
            if (write_q) begin
              done_q  <= NCLI'(1) << win_q;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          if (DDRAM_DOUT_READY) begin
            rdata_q <= DDRAM_DOUT;
            done_q  <= NCLI'(1) << win_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DDRAM_BURSTCNT = BURST_W'(1);
  assign DDRAM_RD       = rd_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = wdata_q;
  assign DDRAM_BE       = be_q;
  assign cli_done       = done_q;
  assign cli_rdata      = rdata_q;

  // Completions never overlap and read/write strobes are mutually exclusive.
  a_done_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(cli_done));
  a_cmd_excl:    assert property (@(posedge clk) disable iff (!reset_n) !(DDRAM_RD && DDRAM_WE));

endmodule

// File: tb/tb_ddram_arbiter.sv
// Scoreboard bench for ddram_arbiter with a small DDR3 responder model.
`timescale 1ns/1ps
module tb_ddram_arbiter;

  localparam int NCLI = 4;
  localparam int AW   = 29;
  localparam int DW   = 64;
  localparam int BW   = 8;

  typedef struct {
    int          cli;
    bit          wr;
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } txn_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCLI-1:0]      cli_req = '0;
  logic [NCLI-1:0]      cli_write = '0;
  logic [NCLI*AW-1:0]   cli_addr = '0;
  logic [NCLI*DW-1:0]   cli_wdata = '0;
  logic [NCLI*BW-1:0]   cli_be = '0;
  logic [NCLI-1:0]      cli_done;
  logic [63:0]          cli_rdata;
  logic                 DDRAM_BUSY = 1'b0;
  logic [7:0]           DDRAM_BURSTCNT;
  logic [28:0]          DDRAM_ADDR;
  logic [63:0]          DDRAM_DOUT = '0;
  logic                 DDRAM_DOUT_READY = 1'b0;
  logic                 DDRAM_RD;
  logic [63:0]          DDRAM_DIN;
  logic [7:0]           DDRAM_BE;
  logic                 DDRAM_WE;

  int          n_cmp = 0;
  int          n_bad = 0;
  txn_t        exp_q[$];
  int          busy_cfg = 0;
  int          rd_lat = 1;
  int          busy_left = 0;
  int          rd_cnt = 0;
  logic [63:0] rd_val = '0;

  ddram_arbiter #(
    .NCLI        (NCLI),
    .VGA_MAX_RUN (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cli_req          (cli_req),
    .cli_write        (cli_write),
    .cli_addr         (cli_addr),
    .cli_wdata        (cli_wdata),
    .cli_be           (cli_be),
    .cli_done         (cli_done),
    .cli_rdata        (cli_rdata),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input int c, input bit wr, input logic [28:0] a,
                              input logic [63:0] d, input logic [7:0] be);
    txn_t t;
    t.cli = c; t.wr = wr; t.addr = a; t.data = d; t.be = be;
    return t;
  endfunction

  task automatic set_cli(input int c, input bit wr, input logic [28:0] a,
                         input logic [63:0] d, input logic [7:0] be);
    cli_write[c]         = wr;
    cli_addr[c*AW +: AW] = a;
    cli_wdata[c*DW +: DW] = d;
    cli_be[c*BW +: BW]   = be;
  endtask

  task automatic do_reset(input int busy, input int lat);
    busy_cfg = busy;
    rd_lat   = lat;
    reset_n  = 1'b0;
    cli_req  = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // DDR responder and scoreboard monitor; sampled on the falling edge.
  always @(negedge clk) begin
    txn_t t;
    if (rd_cnt > 0) begin
      rd_cnt--;
      DDRAM_DOUT_READY = (rd_cnt == 0);
      DDRAM_DOUT       = (rd_cnt == 0) ? rd_val : {$urandom, $urandom};
    end else begin
      DDRAM_DOUT_READY = 1'b0;
      DDRAM_DOUT       = {$urandom, $urandom};
    end

    if (reset_n && cli_done != '0) begin
      if (exp_q.size() == 0) begin
        chk_eq("done_unexpected", 64'(cli_done), 64'd0);
      end else begin
        t = exp_q.pop_front();
        chk_eq($sformatf("done_cli%0d", t.cli), 64'(cli_done), 64'd1 << t.cli);
        if (!t.wr) chk_eq($sformatf("rdata_cli%0d", t.cli), cli_rdata, t.data);
      end
    end

    if (reset_n && (DDRAM_RD || DDRAM_WE)) begin
      if (busy_left > 0) begin
        DDRAM_BUSY = 1'b1;
        busy_left--;
      end else begin
        DDRAM_BUSY = 1'b0;
        busy_left  = busy_cfg;
        if (exp_q.size() == 0) begin
          chk_eq("cmd_unexpected", 64'({DDRAM_RD, DDRAM_WE}), 64'd0);
        end else begin
          t = exp_q[0];
          chk_eq("cmd_we", 64'(DDRAM_WE), 64'(t.wr));
          chk_eq("cmd_rd", 64'(DDRAM_RD), 64'(!t.wr));
          chk_eq("cmd_addr", 64'(DDRAM_ADDR), 64'(t.addr));
          chk_eq("cmd_burst", 64'(DDRAM_BURSTCNT), 64'd1);
          if (t.wr) begin
            chk_eq("cmd_din", DDRAM_DIN, t.data);
            chk_eq("cmd_be", 64'(DDRAM_BE), 64'(t.be));
          end else begin
            rd_val = t.data;
            rd_cnt = rd_lat;
          end
        end
      end
    end else begin
      DDRAM_BUSY = 1'b0;
      busy_left  = busy_cfg;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    int k;
    int t6;
    int rd_cycles;
    int got;
    logic [NCLI-1:0] acc;
    int ord_vga[10] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
    int ord_rr[6]   = '{1, 2, 3, 1, 2, 3};

    // Reset state.
    repeat (3) @(negedge clk);
    chk_eq("rst_rd",    64'(DDRAM_RD), 64'd0);
    chk_eq("rst_we",    64'(DDRAM_WE), 64'd0);
    chk_eq("rst_addr",  64'(DDRAM_ADDR), 64'd0);
    chk_eq("rst_din",   DDRAM_DIN, 64'd0);
    chk_eq("rst_be",    64'(DDRAM_BE), 64'd0);
    chk_eq("rst_done",  64'(cli_done), 64'd0);
    chk_eq("rst_rdata", cli_rdata, 64'd0);
    chk_eq("rst_burst", 64'(DDRAM_BURSTCNT), 64'd1);

    // Single write from client 2.
    do_reset(0, 1);
    set_cli(2, 1'b1, 29'h0001234, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    exp_q.push_back(mk(2, 1'b1, 29'h0001234, 64'hDEADBEEF_CAFEF00D, 8'hFF));
    cli_req[2] = 1'b1;
    @(negedge clk);
    chk_eq("wr_we_c1",   64'(DDRAM_WE), 64'd1);
    chk_eq("wr_rd_c1",   64'(DDRAM_RD), 64'd0);
    chk_eq("wr_addr_c1", 64'(DDRAM_ADDR), 64'h0001234);
    chk_eq("wr_din_c1",  DDRAM_DIN, 64'hDEADBEEF_CAFEF00D);
    chk_eq("wr_be_c1",   64'(DDRAM_BE), 64'hFF);
    chk_eq("wr_done_c1", 64'(cli_done), 64'd0);
    @(negedge clk);
    chk_eq("wr_we_c2",   64'(DDRAM_WE), 64'd0);
    chk_eq("wr_done_c2", 64'(cli_done), 64'b0100);
    cli_req[2] = 1'b0;
    @(negedge clk);
    chk_eq("wr_done_c3", 64'(cli_done), 64'd0);

    // Read from client 1 with BUSY for 3 cycles and 5-cycle data latency.
    do_reset(3, 5);
    set_cli(1, 1'b0, 29'h10, 64'd0, 8'hFF);
    exp_q.push_back(mk(1, 1'b0, 29'h10, 64'h0123456789ABCDEF, 8'hFF));
    cli_req[1] = 1'b1;
    rd_cycles = 0;
    got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      @(negedge clk);
      if (DDRAM_RD) rd_cycles++;
      if (cli_done != '0) begin
        got = 1;
        chk_eq("rd_done",  64'(cli_done), 64'b0010);
        chk_eq("rd_rdata", cli_rdata, 64'h0123456789ABCDEF);
        cli_req[1] = 1'b0;
      end
    end
    chk_eq("rd_seen_done", 64'(got), 64'd1);
    chk_eq("rd_hold_cycles", 64'(rd_cycles), 64'd4);
    repeat (3) @(negedge clk);
    chk_eq("rd_rdata_held", cli_rdata, 64'h0123456789ABCDEF);
    chk_eq("rd_done_clear", 64'(cli_done), 64'd0);

    // Video run limit: client 0 reads and client 3 writes continuously.
    do_reset(0, 1);
    set_cli(0, 1'b0, 29'h0000100, 64'd0, 8'hFF);
    set_cli(3, 1'b1, 29'h0000300, 64'h3333_4444_5555_6666, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      if (ord_vga[i] == 0)
        exp_q.push_back(mk(0, 1'b0, 29'h0000100, 64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF));
      else
        exp_q.push_back(mk(3, 1'b1, 29'h0000300, 64'h3333_4444_5555_6666, 8'h0F));
    end
    cli_req = 4'b1001;
    k = 0;
    for (int c = 0; c < 300 && k < 10; c++) begin
      @(negedge clk);
      if (cli_done != '0) begin
        k++;
        if (k == 10) cli_req = '0;
      end
    end
    chk_eq("vga_done_count", 64'(k), 64'd10);
    repeat (5) @(negedge clk);
    chk_eq("vga_queue_drained", 64'(exp_q.size()), 64'd0);

    // Round-robin among clients 1..3, back-to-back writes.
    do_reset(0, 1);
    for (int c = 1; c < 4; c++)
      set_cli(c, 1'b1, 29'(c * 32'h40), {32'(c), 32'hF00D0000 + 32'(c)}, 8'(8'h11 * c));
    foreach (ord_rr[i])
      exp_q.push_back(mk(ord_rr[i], 1'b1, 29'(ord_rr[i] * 32'h40),
                         {32'(ord_rr[i]), 32'hF00D0000 + 32'(ord_rr[i])}, 8'(8'h11 * ord_rr[i])));
    cli_req = 4'b1110;
    k = 0;
    t6 = 0;
    for (int c = 1; c <= 200 && k < 6; c++) begin
      @(negedge clk);
      if (cli_done != '0) begin
        k++;
        if (k == 6) begin
          cli_req = '0;
          t6 = c;
        end
      end
    end
    chk_eq("rr_done_count", 64'(k), 64'd6);
    chk_eq("rr_b2b_cycles", 64'(t6), 64'd12);
    repeat (4) @(negedge clk);
    chk_eq("rr_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset while waiting for read data; late DOUT_READY must be ignored.
    do_reset(0, 6);
    set_cli(1, 1'b0, 29'h20, 64'd0, 8'hFF);
    exp_q.push_back(mk(1, 1'b0, 29'h20, 64'hBADC0FFE_E0DDF00D, 8'hFF));
    cli_req[1] = 1'b1;
    @(negedge clk);
    chk_eq("rmr_rd_issue", 64'(DDRAM_RD), 64'd1);
    @(negedge clk);
    chk_eq("rmr_rd_accepted", 64'(DDRAM_RD), 64'd0);
    reset_n = 1'b0;
    cli_req = '0;
    exp_q.delete();
    #1;
    chk_eq("rmr_rd",    64'(DDRAM_RD), 64'd0);
    chk_eq("rmr_we",    64'(DDRAM_WE), 64'd0);
    chk_eq("rmr_addr",  64'(DDRAM_ADDR), 64'd0);
    chk_eq("rmr_din",   DDRAM_DIN, 64'd0);
    chk_eq("rmr_be",    64'(DDRAM_BE), 64'd0);
    chk_eq("rmr_done",  64'(cli_done), 64'd0);
    chk_eq("rmr_rdata", cli_rdata, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc |= cli_done;
    end
    chk_eq("rmr_no_done", 64'(acc), 64'd0);
    chk_eq("rmr_rdata_after", cli_rdata, 64'd0);
    chk_eq("rmr_rd_after", 64'(DDRAM_RD), 64'd0);
    set_cli(3, 1'b1, 29'h0000777, 64'h0BAD_CAFE_1234_5678, 8'h3C);
    exp_q.push_back(mk(3, 1'b1, 29'h0000777, 64'h0BAD_CAFE_1234_5678, 8'h3C));
    cli_req[3] = 1'b1;
    @(negedge clk);
    chk_eq("rmr_idle_we", 64'(DDRAM_WE), 64'd1);
    @(negedge clk);
    chk_eq("rmr_idle_done", 64'(cli_done), 64'b1000);
    cli_req[3] = 1'b0;

    // Client 2 drops its request while its write is waiting on BUSY.
    do_reset(2, 1);
    set_cli(2, 1'b1, 29'h0000055, 64'h1122334455667788, 8'hA5);
    exp_q.push_back(mk(2, 1'b1, 29'h0000055, 64'h1122334455667788, 8'hA5));
    cli_req[2] = 1'b1;
    @(negedge clk);
    chk_eq("drop_we_issue", 64'(DDRAM_WE), 64'd1);
    cli_req[2] = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (cli_done != '0) begin
        got = 1;
        chk_eq("drop_done", 64'(cli_done), 64'b0100);
      end
    end
    chk_eq("drop_seen_done", 64'(got), 64'd1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
